// File: rtl/div16_pkg.sv
// Shared constants and FSM encoding for the div16 fixed-point divider.
package div16_pkg;
    localparam int D16_DATA_W = 17;
    localparam int D16_COEF_W = 8;
    localparam int D16_FRAC_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/div16_u_core.sv
// Unsigned restoring divider: one quotient bit per clock, DVD_W steps after i_start.
module div16_u_core #(
    parameter int DVD_W = 24,
    parameter int DVS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_done,
    output logic [DVD_W-1:0] o_quotient
);
    localparam int CNT_W = $clog2(DVD_W);

    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic [DVD_W-1:0] r_dvd;
    logic [DVD_W-1:0] r_quo;
    logic [DVS_W-1:0] r_dvs;
    logic [DVS_W-1:0] r_rem;
    logic [DVS_W:0]   w_shift;
    logic [DVS_W:0]   w_diff;
    logic             w_ge;

    // Remainder stays below the divisor, so the borrow bit is a valid sign.
    assign w_shift = {r_rem, r_dvd[DVD_W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_ge    = ~w_diff[DVS_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= CNT_W'(DVD_W - 1);
            end else if (r_busy) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == '0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_start) begin
            r_dvd <= i_dividend;
            r_dvs <= i_divisor;
            r_rem <= '0;
            r_quo <= '0;
        end else if (r_busy) begin
            r_dvd <= {r_dvd[DVD_W-2:0], 1'b0};
            r_rem <= w_ge ? w_diff[DVS_W-1:0] : w_shift[DVS_W-1:0];
            r_quo <= {r_quo[DVD_W-2:0], w_ge};
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quo;
endmodule

// File: rtl/div16.sv
// Signed fixed-point divider out = (in_17bit <<< 7) / in_8bit, saturated, with
// valid/ready handshake; inverse of the multi16 Q1.7 coefficient multiply.
module div16
    import div16_pkg::*;
#(
    parameter int DATA_W = D16_DATA_W,
    parameter int COEF_W = D16_COEF_W,
    parameter int FRAC_W = D16_FRAC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_17bit,
    input  logic signed [COEF_W-1:0] in_8bit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out,
    output logic                     sat,
    output logic                     div_zero
);
    localparam int DVD_W = DATA_W + FRAC_W;
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DVD_W-1:0] POS_LIM = {{(FRAC_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic [DVD_W-1:0] NEG_LIM = {{FRAC_W{1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_accept;
    logic                      w_core_done;
    logic [DVD_W-1:0]          w_quo;
    logic [DATA_W-1:0]         w_a_raw;
    logic [DATA_W-1:0]         w_a_mag;
    logic [COEF_W-1:0]         w_b_raw;
    logic [COEF_W-1:0]         w_b_mag;
    logic [DVD_W-1:0]          w_dividend;
    logic signed [DATA_W-1:0]  w_fix_out;
    logic                      w_fix_clip;
    logic                      r_neg;
    logic                      r_a_neg;
    logic                      r_zero;
    logic signed [DATA_W-1:0]  r_out;
    logic                      r_sat;
    logic                      r_dz;

    function automatic logic signed [DATA_W-1:0] sat_quo(
        input  logic [DVD_W-1:0] q,
        input  logic             neg,
        output logic             clip
    );
        clip = 1'b0;
        if (neg) begin
            if (q > NEG_LIM) begin
                clip    = 1'b1;
                sat_quo = SAT_MIN;
            end else begin
                sat_quo = $signed(~q[DATA_W-1:0] + DATA_W'(1));
            end
        end else begin
            if (q > POS_LIM) begin
                clip    = 1'b1;
                sat_quo = SAT_MAX;
            end else begin
                sat_quo = $signed(q[DATA_W-1:0]);
            end
        end
    endfunction

    assign w_accept   = in_valid & in_ready;
    assign w_a_raw    = in_17bit;
    assign w_b_raw    = in_8bit;
    // The most negative input's magnitude still fits when read back as unsigned.
    assign w_a_mag    = w_a_raw[DATA_W-1] ? (~w_a_raw + DATA_W'(1)) : w_a_raw;
    assign w_b_mag    = w_b_raw[COEF_W-1] ? (~w_b_raw + COEF_W'(1)) : w_b_raw;
    assign w_dividend = {w_a_mag, {FRAC_W{1'b0}}};

    div16_u_core #(
        .DVD_W (DVD_W),
        .DVS_W (COEF_W)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_accept),
        .i_dividend (w_dividend),
        .i_divisor  (w_b_mag),
        .o_done     (w_core_done),
        .o_quotient (w_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (in_valid)    w_state_nxt = ST_CALC;
            ST_CALC: if (w_core_done) w_state_nxt = ST_FIX;
            ST_FIX:                   w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)   w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_neg   <= in_17bit[DATA_W-1] ^ in_8bit[COEF_W-1];
            r_a_neg <= in_17bit[DATA_W-1];
            r_zero  <= (in_8bit == '0);
        end
    end

    always_comb begin
        w_fix_clip = 1'b0;
        w_fix_out  = sat_quo(w_quo, r_neg, w_fix_clip);
    end

    // FIX stage: sign, clamp and zero-divisor override land in the output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
            r_sat <= 1'b0;
            r_dz  <= 1'b0;
        end else if (r_state == ST_FIX) begin
            if (r_zero) begin
                r_out <= r_a_neg ? SAT_MIN : SAT_MAX;
                r_sat <= 1'b1;
                r_dz  <= 1'b1;
            end else begin
                r_out <= w_fix_out;
                r_sat <= w_fix_clip;
                r_dz  <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out       = r_out;
    assign sat       = r_sat;
    assign div_zero  = r_dz;
endmodule
